// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC rotation scheduler.
// Angles are signed, in units of 0.01 degree.
package cordic_pkg;

    localparam int unsigned ANGLE_W = 16;
    localparam int unsigned ID_W    = 3;
    localparam int          DEG90   = 9000;
    localparam int          DEG180  = 18000;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
        logic            neg;
    } tag_t;

    // Two's-complement negate that maps the most negative code to the most positive one.
    function automatic logic signed [ANGLE_W-1:0] sat_neg(input logic signed [ANGLE_W-1:0] v);
        if (v == {1'b1, {(ANGLE_W-1){1'b0}}}) begin
            return {1'b0, {(ANGLE_W-1){1'b1}}};
        end
        return -v;
    endfunction

endpackage

// File: rtl/cordic_rot_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from the last winner + 1.
// The pointer only moves when a grant is actually issued.
module rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_i,
    input  logic [NREQ-1:0]           req_i,
    output logic [NREQ-1:0]           grant_o,
    output logic [$clog2(NREQ)-1:0]   grant_idx_o
);

    localparam int unsigned IDX_W = $clog2(NREQ);

    logic [IDX_W-1:0] ptr_q;
    logic             found;
    int               idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr_q) + int'(k)) % int'(NREQ);
            if (en_i && !found && req_i[IDX_W'(idx)]) begin
                grant_o[IDX_W'(idx)] = 1'b1;
                grant_idx_o          = IDX_W'(idx);
                found                = 1'b1;
            end
        end
    end

    // Reset value makes requester 0 the first candidate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= IDX_W'(NREQ - 1);
        end else if (found) begin
            ptr_q <= grant_idx_o;
        end
    end

endmodule

// File: rtl/cordic_rot_sched.sv
// Shares one pipelined rotation-mode CORDIC between NREQ requesters, folding angles
// beyond +/-90 deg into range and routing each result back via a fixed-latency tag pipe.
module cordic_rot_sched
    import cordic_pkg::*;
#(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned CORDIC_LAT = 16,
    parameter int unsigned DW         = ANGLE_W
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               hold,
    input  logic [NREQ-1:0]                    req_valid,
    output logic [NREQ-1:0]                    req_ready,
    input  logic [NREQ*DW-1:0]                 req_x,
    input  logic [NREQ*DW-1:0]                 req_y,
    input  logic [NREQ*DW-1:0]                 req_angle,
    output logic signed [DW-1:0]               cordic_x_in,
    output logic signed [DW-1:0]               cordic_y_in,
    output logic signed [DW-1:0]               cordic_angle,
    input  logic signed [DW-1:0]               cordic_x_out,
    input  logic signed [DW-1:0]               cordic_y_out,
    output logic [NREQ-1:0]                    rsp_valid,
    output logic signed [DW-1:0]               rsp_x,
    output logic signed [DW-1:0]               rsp_y,
    output logic [$clog2(CORDIC_LAT+3)-1:0]    in_flight
);

    localparam int unsigned IDX_W = $clog2(NREQ);
    localparam int unsigned FL_W  = $clog2(CORDIC_LAT + 3);
    localparam logic signed [DW-1:0] POS90  = DW'(DEG90);
    localparam logic signed [DW-1:0] NEG90  = DW'(-DEG90);
    localparam logic signed [DW-1:0] DEG180_V = DW'(DEG180);

    logic [NREQ-1:0]  grant;
    logic [IDX_W-1:0] grant_idx;
    logic             arb_en;
    logic             hs;

    logic signed [DW-1:0] sel_x, sel_y, sel_a, fold_a;
    logic                 fold_neg;

    logic signed [DW-1:0] cordic_x_q, cordic_y_q, cordic_a_q;
    logic signed [DW-1:0] cordic_x_d, cordic_y_d, cordic_a_d;
    tag_t                 tag_q [CORDIC_LAT+1];
    tag_t                 tag_d;
    tag_t                 tail;
    logic [NREQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic signed [DW-1:0] rsp_x_q, rsp_y_q, rsp_x_d, rsp_y_d;
    logic [FL_W-1:0]      in_flight_q, in_flight_d;

    assign arb_en = !hold && !rst;

    rr_arbiter #(
        .NREQ        (NREQ)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .en_i        (arb_en),
        .req_i       (req_valid),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    // Grants are only ever issued to valid requesters, so any grant is a handshake.
    assign req_ready = grant;
    assign hs        = |grant;

    // Select winner payload and fold angle into CORDIC range.
    always_comb begin
        sel_x    = '0;
        sel_y    = '0;
        sel_a    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_x = $signed(req_x[i*DW +: DW]);
                sel_y = $signed(req_y[i*DW +: DW]);
                sel_a = $signed(req_angle[i*DW +: DW]);
            end
        end
        fold_a   = sel_a;
        fold_neg = 1'b0;
        if (sel_a > POS90) begin
            fold_a   = sel_a - DEG180_V;
            fold_neg = 1'b1;
        end else if (sel_a < NEG90) begin
            fold_a   = sel_a + DEG180_V;
            fold_neg = 1'b1;
        end
    end

    always_comb begin
        cordic_x_d = '0;
        cordic_y_d = '0;
        cordic_a_d = '0;
        tag_d      = '0;
        if (hs) begin
            cordic_x_d = sel_x;
            cordic_y_d = sel_y;
            cordic_a_d = fold_a;
            tag_d.vld  = 1'b1;
            tag_d.id   = ID_W'(grant_idx);
            tag_d.neg  = fold_neg;
        end

        // Tail tag lines up with the CORDIC result of the same issue.
        tail        = tag_q[CORDIC_LAT];
        rsp_valid_d = '0;
        rsp_x_d     = rsp_x_q;
        rsp_y_d     = rsp_y_q;
        if (tail.vld) begin
            rsp_valid_d = NREQ'(1) << tail.id;
            rsp_x_d     = tail.neg ? DW'(sat_neg(ANGLE_W'(cordic_x_out))) : cordic_x_out;
            rsp_y_d     = tail.neg ? DW'(sat_neg(ANGLE_W'(cordic_y_out))) : cordic_y_out;
        end

        in_flight_d = in_flight_q;
        if (hs && !(|rsp_valid_q)) begin
            in_flight_d = in_flight_q + FL_W'(1);
        end else if (!hs && (|rsp_valid_q)) begin
            in_flight_d = in_flight_q - FL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cordic_x_q  <= '0;
            cordic_y_q  <= '0;
            cordic_a_q  <= '0;
            for (int unsigned i = 0; i <= CORDIC_LAT; i++) begin
                tag_q[i] <= '0;
            end
            rsp_valid_q <= '0;
            rsp_x_q     <= '0;
            rsp_y_q     <= '0;
            in_flight_q <= '0;
        end else begin
            cordic_x_q  <= cordic_x_d;
            cordic_y_q  <= cordic_y_d;
            cordic_a_q  <= cordic_a_d;
            tag_q[0]    <= tag_d;
            for (int unsigned i = 1; i <= CORDIC_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            rsp_valid_q <= rsp_valid_d;
            rsp_x_q     <= rsp_x_d;
            rsp_y_q     <= rsp_y_d;
            in_flight_q <= in_flight_d;
        end
    end

    assign cordic_x_in  = cordic_x_q;
    assign cordic_y_in  = cordic_y_q;
    assign cordic_angle = cordic_a_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_x        = rsp_x_q;
    assign rsp_y        = rsp_y_q;
    assign in_flight    = in_flight_q;

endmodule

// File: tb/tb_cordic_rot_sched.sv
// Bench for cordic_rot_sched: unity-gain rotation model as the CORDIC, plus a
// request/response scoreboard built from direct rotation by the full angle.
module tb_cordic_rot_sched;

    localparam int NREQ = 4;
    localparam int LAT  = 16;
    localparam int DW   = 16;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic hold = 1'b0;
    logic [NREQ-1:0] v = '0;
    int rx [NREQ];
    int ry [NREQ];
    int ra [NREQ];

    logic [NREQ*DW-1:0]    req_x, req_y, req_angle;
    logic [NREQ-1:0]       req_ready, rsp_valid;
    logic signed [DW-1:0]  cordic_x_in, cordic_y_in, cordic_angle;
    logic signed [DW-1:0]  cordic_x_out, cordic_y_out;
    logic signed [DW-1:0]  rsp_x, rsp_y;
    logic [4:0]            in_flight;

    always #5 clk = ~clk;

    always_comb begin
        req_x     = '0;
        req_y     = '0;
        req_angle = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_x[i*DW +: DW]     = DW'(rx[i]);
            req_y[i*DW +: DW]     = DW'(ry[i]);
            req_angle[i*DW +: DW] = DW'(ra[i]);
        end
    end

    cordic_rot_sched #(
        .NREQ         (NREQ),
        .CORDIC_LAT   (LAT),
        .DW           (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hold         (hold),
        .req_valid    (v),
        .req_ready    (req_ready),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_angle    (req_angle),
        .cordic_x_in  (cordic_x_in),
        .cordic_y_in  (cordic_y_in),
        .cordic_angle (cordic_angle),
        .cordic_x_out (cordic_x_out),
        .cordic_y_out (cordic_y_out),
        .rsp_valid    (rsp_valid),
        .rsp_x        (rsp_x),
        .rsp_y        (rsp_y),
        .in_flight    (in_flight)
    );

    function automatic int rot(int x, int y, int a, bit want_y);
        real th, r;
        int  q;
        th = real'(a) * 3.14159265358979 / 18000.0;
        if (want_y) r = real'(x) * $sin(th) + real'(y) * $cos(th);
        else        r = real'(x) * $cos(th) - real'(y) * $sin(th);
        q = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return q;
    endfunction

    function automatic int fold(int a);
        if (a > 9000)  return a - 18000;
        if (a < -9000) return a + 18000;
        return a;
    endfunction

    // Stand-in for rot_mode_top: LAT cycles from registered inputs to outputs.
    logic signed [DW-1:0] mx [LAT];
    logic signed [DW-1:0] my [LAT];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) begin
                mx[k] <= '0;
                my[k] <= '0;
            end
        end else begin
            mx[0] <= DW'(rot(int'(cordic_x_in), int'(cordic_y_in), int'(cordic_angle), 1'b0));
            my[0] <= DW'(rot(int'(cordic_x_in), int'(cordic_y_in), int'(cordic_angle), 1'b1));
            for (int k = 1; k < LAT; k++) begin
                mx[k] <= mx[k-1];
                my[k] <= my[k-1];
            end
        end
    end
    assign cordic_x_out = mx[LAT-1];
    assign cordic_y_out = my[LAT-1];

    typedef struct {
        int due;
        int id;
        int x;
        int y;
    } exp_t;

    exp_t sb [$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   mptr     = NREQ - 1;
    int   mflight  = 0;
    int   exp_cx   = 0;
    int   exp_cy   = 0;
    int   exp_ca   = 0;
    int   peak     = 0;
    logic [NREQ-1:0] hs_last = '0;

    task automatic check(input string tag, input int obs, input int exp, input int tol);
        n_checks++;
        if (obs - exp > tol || exp - obs > tol) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: sample at negedge, compare against the model, advance the model.
    task automatic step();
        int   gi;
        int   idx;
        int   exp_rv;
        bit   have;
        exp_t e;
        @(negedge clk);
        gi = -1;
        if (!hold) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (mptr + k) % NREQ;
                if (gi < 0 && v[idx]) gi = idx;
            end
        end
        check("req_ready", int'(req_ready), (gi >= 0) ? (1 << gi) : 0, 0);
        check("cordic_x_in", int'(cordic_x_in), exp_cx, 0);
        check("cordic_y_in", int'(cordic_y_in), exp_cy, 0);
        check("cordic_angle", int'(cordic_angle), exp_ca, 0);
        have   = (sb.size() > 0) && (sb[0].due == cyc);
        exp_rv = 0;
        if (have) begin
            e      = sb.pop_front();
            exp_rv = 1 << e.id;
        end
        check("rsp_valid", int'(rsp_valid), exp_rv, 0);
        if (have) begin
            check("rsp_x", int'(rsp_x), e.x, 1);
            check("rsp_y", int'(rsp_y), e.y, 1);
        end
        check("in_flight", int'(in_flight), mflight, 0);
        if (int'(in_flight) > peak) peak = int'(in_flight);

        hs_last = '0;
        if (gi >= 0) begin
            sb.push_back('{cyc + LAT + 2, gi, rot(rx[gi], ry[gi], ra[gi], 1'b0),
                           rot(rx[gi], ry[gi], ra[gi], 1'b1)});
            mptr    = gi;
            hs_last = NREQ'(1) << gi;
            exp_cx  = rx[gi];
            exp_cy  = ry[gi];
            exp_ca  = fold(ra[gi]);
            mflight++;
        end else begin
            exp_cx = 0;
            exp_cy = 0;
            exp_ca = 0;
        end
        if (have) mflight--;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic issue(input int id, input int x, input int y, input int a);
        v[id]  = 1'b1;
        rx[id] = x;
        ry[id] = y;
        ra[id] = a;
        for (int n = 0; n < 50; n++) begin
            step();
            if (hs_last[id]) begin
                v[id] = 1'b0;
                return;
            end
        end
        v[id] = 1'b0;
        check("issue_timeout", 0, 1, 0);
    endtask

    // Each requester keeps its request until accepted, then may present a new one.
    task automatic drive(input int pct);
        for (int i = 0; i < NREQ; i++) begin
            if (!v[i] || hs_last[i]) begin
                v[i]  = (int'($urandom_range(99)) < pct);
                rx[i] = int'($urandom_range(40000)) - 20000;
                ry[i] = int'($urandom_range(40000)) - 20000;
                ra[i] = int'($urandom_range(36000)) - 18000;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            rx[i] = 0;
            ry[i] = 0;
            ra[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_rsp_valid", int'(rsp_valid), 0, 0);
        check("reset_in_flight", int'(in_flight), 0, 0);
        check("reset_rsp_x", int'(rsp_x), 0, 0);
        check("reset_cordic_angle", int'(cordic_angle), 0, 0);
        idle(2);

        // Single request, then the fold cases and the saturation corner.
        issue(0, 100, 0, 3000);
        idle(20);
        issue(1, 100, 0, 12000);
        issue(1, 100, 0, -15000);
        issue(1, 100, 0, 9000);
        issue(3, 100, 0, -9000);
        issue(2, -32768, 0, 18000);
        issue(0, 0, -32768, -18000);
        idle(22);

        // All requesters continuously valid.
        peak = 0;
        repeat (24) begin
            drive(100);
            step();
        end
        check("peak_in_flight", peak, LAT + 2, 0);
        v = '0;
        idle(20);

        // Hold with pending requests while earlier results drain.
        repeat (3) begin
            drive(100);
            step();
        end
        hold = 1'b1;
        repeat (5) step();
        hold = 1'b0;
        repeat (4) begin
            drive(100);
            step();
        end
        v = '0;
        idle(20);

        // Random traffic with occasional hold.
        repeat (300) begin
            drive(60);
            hold = ($urandom_range(9) == 0);
            step();
        end
        hold = 1'b0;
        v    = '0;
        idle(20);

        // Reset pulse with ten requests in flight.
        repeat (10) begin
            drive(100);
            step();
        end
        v = '0;
        #2 rst = 1'b1;
        #1;
        check("midrst_rsp_valid", int'(rsp_valid), 0, 0);
        check("midrst_in_flight", int'(in_flight), 0, 0);
        check("midrst_cordic_angle", int'(cordic_angle), 0, 0);
        check("midrst_req_ready", int'(req_ready), 0, 0);
        check("midrst_rsp_x", int'(rsp_x), 0, 0);
        #2 rst = 1'b0;
        sb.delete();
        mflight = 0;
        mptr    = NREQ - 1;
        exp_cx  = 0;
        exp_cy  = 0;
        exp_ca  = 0;
        hs_last = '0;
        @(posedge clk);
        cyc++;
        #1;
        idle(25);
        drive(100);
        step();
        v = '0;
        idle(22);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
